// File: rtl/spi_slave_pkg.sv
// spi_slave_pkg: shared FSM encoding and command codes
// for the spi_slave_gen RAM-path SPI slave
package spi_slave_pkg;

    // gray-encoded so neighbouring states differ in one bit
    typedef enum logic [2:0] {
        IDLE      = 3'b000,
        CHK_CMD   = 3'b001,
        WRITE     = 3'b011,
        READ_ADD  = 3'b010,
        READ_DATA = 3'b110,
        READ_WAIT = 3'b111,
        READ_TX   = 3'b101,
        DONE      = 3'b100
    } spi_state_e;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

endpackage

// File: rtl/spi_par_to_ser.sv
// spi_par_to_ser: DATA_W-wide load/shift register driving MISO
// done flags that the next shift emits the final bit
module spi_par_to_ser #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              load,
    input  logic              shift,
    input  logic [DATA_W-1:0] load_data,
    output logic              miso,
    output logic              done
);
    localparam int CW = $clog2(DATA_W + 1);
    localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

    logic [DATA_W-1:0] sr;
    logic [CW-1:0]     cnt;

    assign done = (cnt == LAST);

    // load, shift out MSB first, or park MISO low
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr   <= '0;
            cnt  <= '0;
            miso <= 1'b0;
        end else if (clear) begin
            cnt  <= '0;
            miso <= 1'b0;
        end else if (load) begin
            sr   <= load_data;
            cnt  <= '0;
            miso <= 1'b0;
        end else if (shift) begin
            miso <= sr[DATA_W-1];
            sr   <= {sr[DATA_W-2:0], 1'b0};
            cnt  <= cnt + CW'(1);
        end else begin
            miso <= 1'b0;
        end
    end

endmodule

// File: rtl/spi_slave_gen.sv
// spi_slave_gen: parametrised SPI slave for the RAM path
// SPI_SLAVE_TIMEOUT_EN adds a bounded wait for tx_valid
module spi_slave_gen
    import spi_slave_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 64
) (
    input  logic              CLK,
    input  logic              rst_n,
    input  logic              SS_n,
    input  logic              MOSI,
    output logic              MISO,
    output logic              rx_valid,
    output logic [DATA_W+1:0] rx_data,
    input  logic              tx_valid,
    input  logic [DATA_W-1:0] tx_data,
    output logic              frame_abort,
    output logic              timeout_err
);
    localparam int F  = DATA_W + 2;
    localparam int BW = $clog2(F);
    localparam logic [BW-1:0] LAST = BW'(F - 1);

    spi_state_e    state, state_n;
    logic [BW-1:0] bit_cnt;
    logic          rd_addr_seen;
    logic          shift_en, last_bit, abort_n;
    logic          load_tx, tx_shift, tx_last;
    logic          set_rd, clr_rd;

`ifdef SPI_SLAVE_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);
    logic [WW-1:0] wait_cnt;
    logic          to_hit;
`endif

    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("spi_slave_gen: TIMEOUT must be at least 1");
    end

    // next state and per-cycle control decode
    always_comb begin
        state_n  = state;
        shift_en = 1'b0;
        last_bit = 1'b0;
        abort_n  = 1'b0;
        load_tx  = 1'b0;
        tx_shift = 1'b0;
        set_rd   = 1'b0;
        clr_rd   = 1'b0;
`ifdef SPI_SLAVE_TIMEOUT_EN
        to_hit   = 1'b0;
`endif
        unique case (state)
            IDLE: begin
                if (!SS_n) state_n = CHK_CMD;
            end
            CHK_CMD: begin
                if (SS_n) begin
                    abort_n = 1'b1;
                    state_n = IDLE;
                end else begin
                    shift_en = 1'b1;
                    if (!MOSI)             state_n = WRITE;
                    else if (rd_addr_seen) state_n = READ_DATA;
                    else                   state_n = READ_ADD;
                end
            end
            WRITE, READ_ADD, READ_DATA: begin
                if (bit_cnt == LAST) begin
                    // last bit wins over a same-edge SS_n release
                    shift_en = 1'b1;
                    last_bit = 1'b1;
                    set_rd   = (state == READ_ADD);
                    if (SS_n)                    state_n = IDLE;
                    else if (state == READ_DATA) state_n = READ_WAIT;
                    else                         state_n = DONE;
                end else if (SS_n) begin
                    abort_n = 1'b1;
                    state_n = IDLE;
                end else begin
                    shift_en = 1'b1;
                end
            end
            READ_WAIT: begin
                if (SS_n) begin
                    abort_n = 1'b1;
                    state_n = IDLE;
                end else if (tx_valid) begin
                    load_tx = 1'b1;
                    state_n = READ_TX;
                end
`ifdef SPI_SLAVE_TIMEOUT_EN
                else if (wait_cnt == WAIT_LAST) begin
                    to_hit  = 1'b1;
                    clr_rd  = 1'b1;
                    state_n = DONE;
                end
`endif
            end
            READ_TX: begin
                if (SS_n) begin
                    abort_n = 1'b1;
                    state_n = IDLE;
                end else begin
                    tx_shift = 1'b1;
                    if (tx_last) begin
                        clr_rd  = 1'b1;
                        state_n = DONE;
                    end
                end
            end
            DONE: begin
                if (SS_n) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    // deserialiser, status pulses and read-address tracking
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            rx_data      <= '0;
            bit_cnt      <= '0;
            rx_valid     <= 1'b0;
            frame_abort  <= 1'b0;
            rd_addr_seen <= 1'b0;
        end else begin
            rx_valid    <= last_bit;
            frame_abort <= abort_n;
            if (shift_en)
                rx_data <= {rx_data[F-2:0], MOSI};
            if (last_bit || SS_n)
                bit_cnt <= '0;
            else if (shift_en)
                bit_cnt <= bit_cnt + BW'(1);
            if (set_rd)
                rd_addr_seen <= 1'b1;
            else if (clr_rd)
                rd_addr_seen <= 1'b0;
        end
    end

`ifdef SPI_SLAVE_TIMEOUT_EN
    // count READ_WAIT cycles without tx_valid
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= to_hit;
            if (state == READ_WAIT && !SS_n && !tx_valid && !to_hit)
                wait_cnt <= wait_cnt + WW'(1);
            else
                wait_cnt <= '0;
        end
    end
`else
    assign timeout_err = 1'b0;
`endif

    spi_par_to_ser #(
        .DATA_W(DATA_W)
    ) u_p2s (
        .clk      (CLK),
        .rst_n    (rst_n),
        .clear    (SS_n),
        .load     (load_tx),
        .shift    (tx_shift),
        .load_data(tx_data),
        .miso     (MISO),
        .done     (tx_last)
    );

endmodule
